// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq
//   in_valid/in_ready   operand transfer handshake (opcode, in_a, in_b)
//   out_valid/out_ready result transfer handshake (alu_out, a_is_zero, carry, zero)
//   master: operand source and result consumer; slave: the ALU
interface alu_seq_if #(parameter int unsigned WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             a_is_zero;
    logic             carry;
    logic             zero;
    modport master (
        output in_valid, opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, alu_out, a_is_zero, carry, zero
    );
    modport slave (
        input  in_valid, opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, alu_out, a_is_zero, carry, zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered 16-opcode ALU with valid/ready handshake and carry/zero flags
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_seq_if.slave: operands/opcode in, registered result and flags out
//   Define ALU_SEQ_MUL_EN to make opcode 12 a WIDTH+1 cycle shift-add multiply;
//   otherwise opcode 12 passes A through in one cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum_d;
`else
    typedef enum logic {IDLE, DONE} state_t;
`endif
    state_t           state_q;
    logic [WIDTH-1:0] alu_out_q, res_d;
    logic             out_valid_q, carry_q, zero_q, a_is_zero_q, carry_d;
    logic [31:0]      sh;
    logic             accept;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.a_is_zero = a_is_zero_q;

    always_comb begin
        sh      = 32'(bus.in_b) % WIDTH;
        res_d   = bus.in_a;
        carry_d = 1'b0;
        case (bus.opcode)
            4'd2:    {carry_d, res_d} = {1'b0, bus.in_a} + {1'b0, bus.in_b};
            4'd3:    res_d = bus.in_a & bus.in_b;
            4'd4:    res_d = bus.in_a ^ bus.in_b;
            4'd5:    res_d = bus.in_b;
            4'd8:    begin
                res_d   = bus.in_a - bus.in_b;
                carry_d = bus.in_a < bus.in_b;
            end
            4'd9:    res_d = bus.in_a | bus.in_b;
            4'd10:   res_d = bus.in_a << sh;
            4'd11:   res_d = bus.in_a >> sh;
            default: ;
        endcase
`ifdef ALU_SEQ_MUL_EN
        // partial-product add for the multiplier bit currently at lo_q[0]
        sum_d = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            a_is_zero_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q       <= '0;
`endif
        end else begin
`ifdef ALU_SEQ_MUL_EN
            // {hi_q, lo_q} shifts right each step; after WIDTH steps it holds A*B,
            // and one more edge registers the result
            if (state_q == BUSY) begin
                if (cnt_q == CW'(WIDTH)) begin
                    alu_out_q   <= lo_q;
                    carry_q     <= |hi_q;
                    zero_q      <= lo_q == '0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    {hi_q, lo_q} <= {sum_d, lo_q[WIDTH-1:1]};
                    cnt_q        <= cnt_q + 1'b1;
                end
            end else
`endif
            if (accept) begin
                a_is_zero_q <= bus.in_a == '0;
`ifdef ALU_SEQ_MUL_EN
                if (bus.opcode == 4'd12) begin
                    mcand_q     <= bus.in_a;
                    lo_q        <= bus.in_b;
                    hi_q        <= '0;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= BUSY;
                end else
`endif
                begin
                    alu_out_q   <= res_d;
                    carry_q     <= carry_d;
                    zero_q      <= res_d == '0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
            end else if (state_q == DONE && bus.out_ready) begin
                out_valid_q <= 1'b0;
                state_q     <= IDLE;
            end
        end
    end
endmodule
